// File: rtl/ws2812_strip.sv
// ---------------------------------------------------------------------------
// ws2812_strip
// Streams NUM_LEDS 24-bit GRB pixels from a synchronous pixel RAM (read
// latency 1) onto a WS2812 data line. After the last bit it holds the line
// low for RST_CYCLES cycles, which is the latch gap, and then pulses
// frame_done.
//
// Ports
//   clk         in   1   system clock
//   rst         in   1   synchronous reset, active-high
//   start       in   1   request one frame; only looked at while idle
//   busy        out  1   frame in progress (accepted start .. frame_done)
//   frame_done  out  1   one-cycle pulse at the end of the latch gap
//   pix_rd      out  1   pixel RAM read strobe (one cycle per pixel)
//   pix_addr    out  AW  pixel RAM address, valid while pix_rd=1
//   pix_data    in   24  pixel word, valid the cycle after pix_rd
//   dat         out  1   registered WS2812 data line
//
// Timing
//   The start-sampling edge is edge k. FETCH issues the read for pixel 0.
//   The word is captured at edge k+2 and SEND begins. dat is registered one
//   stage behind the symbol counter, so the first rise appears after edge
//   k+3. While a pixel is being sent, the next pixel is read into a shadow
//   register. This lets pixel boundaries run without a gap.
// ---------------------------------------------------------------------------
module ws2812_strip #(
    parameter int NUM_LEDS   = 60,
    parameter int T_SYM      = 16,
    parameter int T0H        = 5,
    parameter int T1H        = 10,
    parameter int RST_CYCLES = 1024,
    localparam int AW        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          frame_done,
    output logic          pix_rd,
    output logic [AW-1:0] pix_addr,
    input  logic [23:0]   pix_data,
    output logic          dat
);

    localparam int SW = (T_SYM > 1) ? $clog2(T_SYM) : 1;
    localparam int LW = $clog2(RST_CYCLES + 1);

    localparam logic [SW-1:0] SYM_LAST   = SW'(T_SYM - 1);
    localparam logic [SW-1:0] T0H_C      = SW'(T0H);
    localparam logic [SW-1:0] T1H_C      = SW'(T1H);
    localparam logic [LW-1:0] LATCH_LAST = LW'(RST_CYCLES);
    localparam logic [AW-1:0] PIX_LAST   = AW'(NUM_LEDS - 1);
    localparam logic [4:0]    BIT_MSB    = 5'd23;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    // The line is high for the first T1H (for a '1') or the first T0H
    // (for a '0') cycles of a symbol.
    function automatic logic sym_high(input logic bit_val, input logic [SW-1:0] cnt);
        logic [SW-1:0] thr;
        thr = bit_val ? T1H_C : T0H_C;
        return (cnt < thr);
    endfunction

    state_t        state_q,    state_d;
    logic [SW-1:0] symcnt_q,   symcnt_d;
    logic [4:0]    bitidx_q,   bitidx_d;
    logic [AW-1:0] pixidx_q,   pixidx_d;
    logic [LW-1:0] latchcnt_q, latchcnt_d;
    logic [23:0]   shift_q,    shift_d;
    logic [23:0]   shadow_q,   shadow_d;
    logic          rdvld_q,    rdvld_d;
    logic          dat_q,      dat_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;
    logic          pixrd_q,    pixrd_d;
    logic [AW-1:0] pixaddr_q,  pixaddr_d;

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign pix_rd     = pixrd_q;
    assign pix_addr   = pixaddr_q;
    assign dat        = dat_q;

    // Next-state, counter and output computation
    always_comb begin
        state_d    = state_q;
        symcnt_d   = symcnt_q;
        bitidx_d   = bitidx_q;
        pixidx_d   = pixidx_q;
        latchcnt_d = latchcnt_q;
        shift_d    = shift_q;
        shadow_d   = shadow_q;
        // RAM data is valid exactly one cycle after a read strobe.
        rdvld_d    = pixrd_q;
        dat_d      = 1'b0;
        done_d     = 1'b0;
        pixrd_d    = 1'b0;
        pixaddr_d  = pixaddr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    pixidx_d   = {AW{1'b0}};
                    symcnt_d   = {SW{1'b0}};
                    bitidx_d   = BIT_MSB;
                    latchcnt_d = {LW{1'b0}};
                    pixrd_d    = 1'b1;
                    pixaddr_d  = {AW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_FETCH: begin
                if (rdvld_q) begin
                    shift_d  = pix_data;
                    state_d  = S_SEND;
                    symcnt_d = {SW{1'b0}};
                    bitidx_d = BIT_MSB;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_SEND: begin
                dat_d = sym_high(shift_q[23], symcnt_q);
                // The prefetched word lands in the shadow register.
                if (rdvld_q) begin
                    shadow_d = pix_data;
                end else begin
                    shadow_d = shadow_q;
                end
                if (symcnt_q == SYM_LAST) begin
                    symcnt_d = {SW{1'b0}};
                    if (bitidx_q == 5'd0) begin
                        if (pixidx_q == PIX_LAST) begin
                            state_d    = S_LATCH;
                            latchcnt_d = {LW{1'b0}};
                        end else begin
                            // Bit 0 is done: the next pixel continues without a lost cycle.
                            pixidx_d = pixidx_q + AW'(1);
                            bitidx_d = BIT_MSB;
                            shift_d  = shadow_q;
                        end
                    end else begin
                        bitidx_d = bitidx_q - 5'd1;
                        shift_d  = {shift_q[22:0], 1'b0};
                    end
                end else begin
                    symcnt_d = symcnt_q + SW'(1);
                end
            end

            S_LATCH: begin
                // The counter runs 0..RST_CYCLES. dat lags by one stage, so
                // the line shows exactly RST_CYCLES low cycles before frame_done.
                if (latchcnt_q == LATCH_LAST) begin
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                    latchcnt_d = {LW{1'b0}};
                end else begin
                    latchcnt_d = latchcnt_q + LW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Prefetch: the strobe is high during symcnt 0 of bit 23 of pixel n,
        // but only when a pixel n+1 exists.
        if ((state_d == S_SEND) && (bitidx_d == BIT_MSB) &&
            (symcnt_d == {SW{1'b0}}) && (pixidx_d != PIX_LAST)) begin
            pixrd_d   = 1'b1;
            pixaddr_d = pixidx_d + AW'(1);
        end else begin
            pixrd_d   = pixrd_d;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            symcnt_q   <= {SW{1'b0}};
            bitidx_q   <= 5'd0;
            pixidx_q   <= {AW{1'b0}};
            latchcnt_q <= {LW{1'b0}};
            shift_q    <= 24'd0;
            shadow_q   <= 24'd0;
            rdvld_q    <= 1'b0;
            dat_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pixrd_q    <= 1'b0;
            pixaddr_q  <= {AW{1'b0}};
        end else begin
            state_q    <= state_d;
            symcnt_q   <= symcnt_d;
            bitidx_q   <= bitidx_d;
            pixidx_q   <= pixidx_d;
            latchcnt_q <= latchcnt_d;
            shift_q    <= shift_d;
            shadow_q   <= shadow_d;
            rdvld_q    <= rdvld_d;
            dat_q      <= dat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pixrd_q    <= pixrd_d;
            pixaddr_q  <= pixaddr_d;
        end
    end

endmodule

// File: tb/tb_ws2812_strip.sv
// ---------------------------------------------------------------------------
// tb_ws2812_strip
// Directed bench for ws2812_strip. It uses four instances with different
// parameter sets:
//   0: NUM_LEDS=1, defaults
//   1: NUM_LEDS=3, defaults
//   2: NUM_LEDS=2, defaults
//   3: NUM_LEDS=2, T_SYM=8, T0H=2, T1H=5, RST_CYCLES=4
//
// Each instance has its own latency-1 pixel RAM model. When no read is
// requested, the RAM model returns filler data.
//
// The expected waveforms are computed from the frame timing. t counts edges
// after the start-sampling edge:
//   - dat follows the symbols for 3 <= t < 3+NB.
//   - busy is high for t < E.
//   - frame_done is high at t == E.
//   - pix_rd is high at t==0 (address 0), and at t == 2+(p-1)*24*T_SYM
//     (address p) for p = 1 .. NUM_LEDS-1.
//   where NB = NUM_LEDS*24*T_SYM and E = 3+NB+RST_CYCLES.
// ---------------------------------------------------------------------------
module tb_ws2812_strip;

    logic        clk;
    logic        rst;
    logic [3:0]  start_v;
    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [3:0]  rd_v;
    logic [3:0]  dat_v;
    logic [23:0] pd [4];
    logic [7:0]  addr_a [4];
    logic [0:0]  a0;
    logic [1:0]  a1;
    logic [0:0]  a2;
    logic [0:0]  a3;
    logic [23:0] pix_mem [4][4];

    int vectors     = 0;
    int miscompares = 0;

    int n_t    [4] = '{1, 3, 2, 2};
    int tsym_t [4] = '{16, 16, 16, 8};
    int t0_t   [4] = '{5, 5, 5, 2};
    int t1_t   [4] = '{10, 10, 10, 5};
    int rc_t   [4] = '{1024, 1024, 1024, 4};

    assign addr_a[0] = {7'd0, a0};
    assign addr_a[1] = {6'd0, a1};
    assign addr_a[2] = {7'd0, a2};
    assign addr_a[3] = {7'd0, a3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ws2812_strip #(.NUM_LEDS(1)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]),
        .frame_done(done_v[0]), .pix_rd(rd_v[0]), .pix_addr(a0),
        .pix_data(pd[0]), .dat(dat_v[0]));

    ws2812_strip #(.NUM_LEDS(3)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]),
        .frame_done(done_v[1]), .pix_rd(rd_v[1]), .pix_addr(a1),
        .pix_data(pd[1]), .dat(dat_v[1]));

    ws2812_strip #(.NUM_LEDS(2)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]),
        .frame_done(done_v[2]), .pix_rd(rd_v[2]), .pix_addr(a2),
        .pix_data(pd[2]), .dat(dat_v[2]));

    ws2812_strip #(.NUM_LEDS(2), .T_SYM(8), .T0H(2), .T1H(5), .RST_CYCLES(4)) u_d (
        .clk(clk), .rst(rst), .start(start_v[3]), .busy(busy_v[3]),
        .frame_done(done_v[3]), .pix_rd(rd_v[3]), .pix_addr(a3),
        .pix_data(pd[3]), .dat(dat_v[3]));

    // Pixel RAMs with one cycle of read latency
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            pd[i] <= rd_v[i] ? pix_mem[i][addr_a[i][1:0]] : 24'h5A5A5A;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame on instance s. The caller must be aligned to a negedge.
    // If hold is set, start stays high. p1 and p2 are extra start pulses,
    // given as t values.
    task automatic run_frame(input int s, input bit hold, input int p1, input int p2,
                             input string tag);
        int   n, tsym, t0, t1, rc, nb, e;
        int   dat_err, rd_err, busy_err, done_err, rd_cnt, done_cnt, first_bad;
        int   sym, ph, pix, bt, ea;
        logic ed, er;
        n = n_t[s]; tsym = tsym_t[s]; t0 = t0_t[s]; t1 = t1_t[s]; rc = rc_t[s];
        nb = n * 24 * tsym;
        e  = 3 + nb + rc;
        dat_err = 0; rd_err = 0; busy_err = 0; done_err = 0;
        rd_cnt = 0; done_cnt = 0; first_bad = -1;
        start_v[s] = 1'b1;
        @(posedge clk);
        for (int t = 0; t <= e; t++) begin
            @(negedge clk);
            ed = 1'b0;
            if (t >= 3 && t < 3 + nb) begin
                sym = (t - 3) / tsym;
                ph  = (t - 3) % tsym;
                pix = sym / 24;
                bt  = 23 - (sym % 24);
                ed  = (ph < (pix_mem[s][pix][bt] ? t1 : t0));
            end
            if (dat_v[s] !== ed) begin
                if (first_bad < 0) first_bad = t;
                dat_err++;
            end
            er = 1'b0; ea = 0;
            if (t == 0) begin
                er = 1'b1;
            end else if (t >= 2 && ((t - 2) % (24 * tsym)) == 0 &&
                         ((t - 2) / (24 * tsym)) + 1 < n) begin
                er = 1'b1;
                ea = ((t - 2) / (24 * tsym)) + 1;
            end
            if (rd_v[s] !== er || (er && addr_a[s] !== 8'(ea))) rd_err++;
            if (rd_v[s] === 1'b1) rd_cnt++;
            if (busy_v[s] !== (t < e)) busy_err++;
            if (done_v[s] !== (t == e)) done_err++;
            if (done_v[s] === 1'b1) done_cnt++;
            start_v[s] = hold || (t == p1) || (t == p2);
        end
        check({tag, "_dat_errs"},    dat_err,   0);
        check({tag, "_dat_firstbad"}, first_bad, -1);
        check({tag, "_rd_errs"},     rd_err,    0);
        check({tag, "_rd_count"},    rd_cnt,    n);
        check({tag, "_busy_errs"},   busy_err,  0);
        check({tag, "_done_errs"},   done_err,  0);
        check({tag, "_done_count"},  done_cnt,  1);
    endtask

    initial begin
        int quiet_err;
        int tr;
        rst     = 1'b1;
        start_v = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) pix_mem[i][j] = 24'h000000;
        end
        pix_mem[0][0] = 24'hFF22FD;
        pix_mem[1][0] = 24'h000001;
        pix_mem[1][1] = 24'h800000;
        pix_mem[1][2] = 24'hAAAAAA;
        pix_mem[2][0] = 24'h123456;
        pix_mem[2][1] = 24'hF0F0F0;
        pix_mem[3][0] = 24'hC3A501;
        pix_mem[3][1] = 24'h5A0FF0;

        // Reset state of every instance
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_dat%0d", i),  dat_v[i],  1'b0);
            check($sformatf("rst_busy%0d", i), busy_v[i], 1'b0);
            check($sformatf("rst_done%0d", i), done_v[i], 1'b0);
            check($sformatf("rst_rd%0d", i),   rd_v[i],   1'b0);
            check($sformatf("rst_addr%0d", i), addr_a[i], 8'd0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single pixel, bit-exact pattern and frame length
        run_frame(0, 1'b0, -1, -1, "t1");
        repeat (3) @(negedge clk);

        // 2: three pixels, contiguous symbols, reads at addresses 0, 1, 2
        run_frame(1, 1'b0, -1, -1, "t2");
        repeat (3) @(negedge clk);

        // 3: start pulses in mid-SEND and mid-LATCH are ignored
        run_frame(1, 1'b0, 500, 3 + 1152 + 500, "t3");
        @(negedge clk);
        check("t3_idle_busy", busy_v[1], 1'b0);
        repeat (2) @(negedge clk);

        // 4: reset during pixel 1, bit 7, then a clean restart
        tr = 2 + 24 * 16 + 16 * 16 + 5;
        start_v[1] = 1'b1;
        @(posedge clk);
        for (int t = 0; t < tr; t++) begin
            @(negedge clk);
            start_v[1] = 1'b0;
        end
        @(negedge clk);
        check("t4_busy_before", busy_v[1], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("t4_dat",  dat_v[1],  1'b0);
        check("t4_busy", busy_v[1], 1'b0);
        check("t4_done", done_v[1], 1'b0);
        check("t4_rd",   rd_v[1],   1'b0);
        rst = 1'b0;
        quiet_err = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done_v[1] !== 1'b0 || busy_v[1] !== 1'b0 || dat_v[1] !== 1'b0) quiet_err++;
        end
        check("t4_quiet_after_rst", quiet_err, 0);
        run_frame(1, 1'b0, -1, -1, "t4_restart");
        repeat (3) @(negedge clk);

        // 5: start held high gives back-to-back frames
        run_frame(2, 1'b1, -1, -1, "t5a");
        run_frame(2, 1'b1, -1, -1, "t5b");
        start_v[2] = 1'b0;
        @(negedge clk);
        check("t5_stop_busy", busy_v[2], 1'b0);
        repeat (2) @(negedge clk);

        // 6: short timing parameters
        run_frame(3, 1'b1, -1, -1, "t6a");
        run_frame(3, 1'b0, -1, -1, "t6b");
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
